// File: rtl/led7seg_scan_pkg.sv
// led7seg_scan_pkg: shared scan-controller types, constants and one-hot helper
// Contents:
//   state_t  - scan FSM encodings OFF/SHOW/GUARD
//   BCD_MAX  - largest nibble value that is a displayable decimal digit
//   onehot() - 32-bit one-hot select for an index, reused by scan-style blocks
package led7seg_scan_pkg;
  typedef enum logic [1:0] {OFF, SHOW, GUARD} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [31:0] onehot(input int i);
    onehot = 32'd1 << i;
  endfunction
endpackage

// File: rtl/led7seg_lz_mask.sv
// led7seg_lz_mask: leading-zero blanking mask for a BCD display word
// Ports:
//   value    in  4*NUM_DIGITS  BCD nibbles, nibble 0 least significant
//   blank_lz in  1             suppression enable
//   lz_blank out NUM_DIGITS    1 = position is a suppressed leading zero
module led7seg_lz_mask #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   lz_blank
);
  // digit 0 always shows, so a zero word still displays "0"
  assign lz_blank[0] = 1'b0;
  // any non-zero nibble (including >9) at or above position g stops blanking
  for (genvar g = 1; g < NUM_DIGITS; g++) begin : gen_lz
    assign lz_blank[g] = blank_lz & ~|value[4*NUM_DIGITS-1:4*g];
  end
endmodule

// File: rtl/led7seg_scan.sv
// led7seg_scan: time-multiplexed scan controller for a multi-digit 7-segment display
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   load                          strobe capturing value/digit_en/blank_lz
//   value[4*NUM_DIGITS]           BCD display word
//   digit_en[NUM_DIGITS]          per-position enable mask
//   blank_lz                      leading-zero suppression enable
//   digit[4], valid               nibble and valid towards the decoder
//   an[NUM_DIGITS]                one-hot active-high anode select
//   frame                         pulse on the first cycle of position 0
module led7seg_scan
  import led7seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [3:0]              digit,
  output logic                    valid,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);
  localparam int CMAX = SCAN_DIV > GUARD_CYC ? SCAN_DIV : GUARD_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC == 0 ? 0 : GUARD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [4*NUM_DIGITS-1:0] pend_value, src_value;
  logic [NUM_DIGITS-1:0] pend_en, src_en, an_n, lz;
  logic pend_blz, src_blz, enter, valid_n, frame_n;
  logic [3:0] digit_n, nib;
  // a load on a slot-entry edge is shown immediately instead of waiting a slot
  assign src_value = load ? value : pend_value;
  assign src_en = load ? digit_en : pend_en;
  assign src_blz = load ? blank_lz : pend_blz;
  assign idx_inc = idx == IDX_LAST ? '0 : idx + IW'(1);
  assign nib = src_value[4*idx_n +: 4];
  led7seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz (
    .value(src_value),
    .blank_lz(src_blz),
    .lz_blank(lz)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt + CW'(1);
    enter = 1'b0;
    an_n = an;
    digit_n = digit;
    valid_n = valid;
    frame_n = 1'b0;
    case (state)
      OFF: begin
        cnt_n = cnt;
        enter = load;
        idx_n = '0;
      end
      SHOW:
        if (cnt == SCAN_LAST) begin
          if (GUARD_CYC == 0) begin
            enter = 1'b1;
            idx_n = idx_inc;
          end else begin
            state_n = GUARD;
            cnt_n = '0;
            an_n = '0;
            valid_n = 1'b0;
          end
        end
      GUARD:
        if (cnt == GUARD_LAST) begin
          enter = 1'b1;
          idx_n = idx_inc;
        end
      default: state_n = OFF;
    endcase
    // slot outputs are snapshotted once at entry and held for the whole slot
    if (enter) begin
      state_n = SHOW;
      cnt_n = '0;
      an_n = NUM_DIGITS'(onehot(int'(idx_n)));
      digit_n = nib;
      valid_n = src_en[idx_n] & ~lz[idx_n] & (nib <= BCD_MAX);
      frame_n = idx_n == '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      idx <= '0;
      cnt <= '0;
      digit <= '0;
      valid <= 1'b0;
      an <= '0;
      frame <= 1'b0;
      pend_value <= '0;
      pend_en <= '0;
      pend_blz <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      digit <= digit_n;
      valid <= valid_n;
      an <= an_n;
      frame <= frame_n;
      if (load) begin
        pend_value <= value;
        pend_en <= digit_en;
        pend_blz <= blank_lz;
      end
    end
  end
endmodule

// File: tb/tb_led7seg_scan.sv
// tb_led7seg_scan: scoreboard bench for led7seg_scan (4 digits, 4-cycle slots, 1-cycle guard)
module tb_led7seg_scan;
  typedef struct {
    logic [3:0] an;
    logic [3:0] digit;
    logic       valid;
    logic       frame;
    int         gap;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] digit_en = '0, digit, an;
  logic valid, frame;
  int passed = 0, total = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  led7seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .digit_en(digit_en),
    .blank_lz(blank_lz), .digit(digit), .valid(valid), .an(an), .frame(frame)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  // monitor: one scoreboard pop per slot start, plus slot length/hold and dark checks
  bit in_slot = 0, hold_ok = 0;
  int dark = 0, len = 0;
  logic [3:0] s_an, s_digit;
  logic s_valid;
  task automatic end_slot();
    check("slot_len", len, 4);
    check("slot_hold", {31'd0, hold_ok}, 1);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      in_slot = 0;
      dark = 0;
    end else if (an == 4'd0) begin
      check("dark_outputs", {valid, frame}, 0);
      if (in_slot) end_slot();
      in_slot = 0;
      dark++;
    end else if (!in_slot || an != s_an) begin
      if (in_slot) end_slot();
      in_slot = 1;
      len = 1;
      hold_ok = 1;
      s_an = an;
      s_digit = digit;
      s_valid = valid;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("slot", {an, digit, valid, frame}, {e.an, e.digit, e.valid, e.frame});
        if (e.gap >= 0) check("guard_gap", dark, e.gap);
      end
      dark = 0;
    end else begin
      len++;
      if (digit != s_digit || valid != s_valid || frame) hold_ok = 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] a, input logic [3:0] d, input logic v, input logic f, input int g);
    exp_t e;
    e.an = a;
    e.digit = d;
    e.valid = v;
    e.frame = f;
    e.gap = g;
    q.push_back(e);
  endtask
  // one full scan of hand-computed digits (nibble i shown on idx i) and valid mask
  task automatic exp4(input logic [15:0] digs, input logic [3:0] vld, input bit first);
    for (int i = 0; i < 4; i++)
      push(4'd1 << i, digs[4*i +: 4], vld[i], i == 0, (first && i == 0) ? -1 : 1);
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic blz);
    value = v;
    digit_en = en;
    blank_lz = blz;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain", q.size(), 0);
    repeat (6) tick();
  endtask
  initial begin
    reset_dut();
    repeat (100) begin
      tick();
      check("idle_dark", {an, digit, valid, frame}, 0);
    end
    exp4(16'h1234, 4'hF, 1);
    exp4(16'h1234, 4'hF, 0);
    do_load(16'h1234, 4'hF, 1'b0);
    drain();
    reset_dut();
    exp4(16'h0050, 4'b0011, 1);
    do_load(16'h0050, 4'hF, 1'b1);
    drain();
    reset_dut();
    exp4(16'h0000, 4'b0001, 1);
    do_load(16'h0000, 4'hF, 1'b1);
    drain();
    reset_dut();
    exp4(16'h12AF, 4'b1100, 1);
    do_load(16'h12AF, 4'hF, 1'b0);
    drain();
    reset_dut();
    exp4(16'h1234, 4'b0101, 1);
    do_load(16'h1234, 4'b0101, 1'b0);
    drain();
    reset_dut();
    exp4(16'h9934, 4'hF, 1);
    exp4(16'h9999, 4'hF, 0);
    do_load(16'h1234, 4'hF, 1'b0);
    repeat (6) tick();
    do_load(16'h9999, 4'hF, 1'b0);
    drain();
    reset_dut();
    exp4(16'h9994, 4'hF, 1);
    do_load(16'h1234, 4'hF, 1'b0);
    repeat (4) tick();
    do_load(16'h9999, 4'hF, 1'b0);
    drain();
    reset_dut();
    push(4'd1, 4'd4, 1'b1, 1'b1, -1);
    do_load(16'h1234, 4'hF, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_show", {an, digit, valid, frame}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) begin
      tick();
      check("dark_after_rst", {an, digit, valid, frame}, 0);
    end
    exp4(16'h1234, 4'hF, 1);
    do_load(16'h1234, 4'hF, 1'b0);
    drain();
    reset_dut();
    push(4'd1, 4'd4, 1'b1, 1'b1, -1);
    do_load(16'h1234, 4'hF, 1'b0);
    repeat (4) tick();
    check("guard_hold", {an, digit, valid, frame}, {4'h0, 4'h4, 1'b0, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async_rst_guard", {an, digit, valid, frame}, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      check("dark_after_rst", {an, digit, valid, frame}, 0);
    end
    exp4(16'h1234, 4'hF, 1);
    do_load(16'h1234, 4'hF, 1'b0);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
